dot_product_accum: RTL
======================

Name: dot_product_accum

Overview:
Chunked, handshaked successor to the single-cycle sigma-weighted dot-product tree. Each beat accepts LANES elements of one J column plus the matching sigma bits and reduces them in a combinational adder tree. The tree output is accumulated over VECTOR_SIZE/LANES beats into one signed dot product. The block sits between the J-column fetch stage and the energy/field update logic, so that full-length vectors can be processed with a narrower tree.

Parameters:
VECTOR_SIZE, 256, total elements per dot product; must be a multiple of LANES.
LANES, 64, elements reduced per accepted beat; power of two, at least 2.
J_ELEMENT_WIDTH, 4, width of each unsigned J element.
RESULT_WIDTH, J_ELEMENT_WIDTH+$clog2(VECTOR_SIZE)+1, signed accumulator and output width (derived).
CHUNKS, VECTOR_SIZE/LANES, beats per vector (derived).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of the partial vector and any pending output
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
sigma  in  LANES  1 = add element, 0 = subtract element
J_chunk  in  J_ELEMENT_WIDTH x [0:LANES-1]  unsigned elements, unpacked array
chunk_idx  out  $clog2(CHUNKS) (min 1)  index of the next beat expected
out_valid  out  1  dot_out valid
out_ready  in  1  consumer accepts the result
dot_out  out  RESULT_WIDTH signed  completed dot product

Behaviour:
- Reset (rst_n=0, async): state ACCUM; chunk_idx=0; accumulator=0; out_valid=0; dot_out=0; in_ready=1 once rst_n is released.
- Element term: zero-extend J to RESULT_WIDTH, then add it if sigma=1 or negate it if sigma=0. The partial sum is the tree sum of LANES terms. All arithmetic is two's complement at RESULT_WIDTH and cannot overflow by construction.
- FSM has two states, ACCUM and HOLD.
- ACCUM: in_ready=1.
  - Accepted beat with chunk_idx=0: acc <= partial (the first beat overwrites the accumulator; no clearing cycle is needed).
  - Other accepted beats: acc <= acc + partial.
  - chunk_idx increments on each accepted beat.
  - Beat with chunk_idx=CHUNKS-1: dot_out <= acc+partial (or partial if CHUNKS=1); out_valid <= 1; chunk_idx <= 0; state <= HOLD.
- HOLD: in_ready=0. dot_out and out_valid stay stable until out_ready=1. On the out_valid&&out_ready cycle: out_valid <= 0 and state <= ACCUM. A new beat can be accepted on the following cycle.
- Latency: out_valid rises in the cycle after the last beat is accepted (1 cycle).
- in_valid=0 in ACCUM: no state change; bubbles between beats are legal.
- Beats with in_valid=0 are ignored. sigma and J_chunk are don't-care unless a beat is accepted.
- flush=1 (highest priority after reset): chunk_idx <= 0, out_valid <= 0, state <= ACCUM. Any beat or out_ready in the same cycle is discarded. dot_out keeps its last value.
- Reset mid-vector discards the partial sum. The next vector starts at chunk_idx=0.
- Output register dot_out updates only on the last accepted beat.

Optional Feature:
DOTACC_PIPE_EN.
- Defined: one register stage follows the adder tree (partial, first-beat flag and last-beat flag are registered). Accumulation happens one cycle later, and out_valid rises 2 cycles after the last beat.
  - in_ready is still 1 in ACCUM, so back-to-back beats run at full rate.
  - State moves to HOLD when the last beat is accepted.
  - flush and reset also clear the pipeline stage's valid bit.
- Undefined: no pipeline register; 1-cycle latency as in Behaviour.

Test Plan:
(All cases use the default parameters, giving RESULT_WIDTH=13 and CHUNKS=4.)
1. Four back-to-back beats, sigma all 1, element i has J=i mod 16 -> dot_out=1920, out_valid one cycle after beat 3 (two with DOTACC_PIPE_EN), chunk_idx sequence 0,1,2,3,0.
2. Same J, sigma all 0 -> dot_out=-1920. Then sigma[i]=i%2 (odd add) -> dot_out=128. All J=15, sigma all 1 -> dot_out=3840.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> dot_out held, in_ready=0, offered beats not accepted. out_ready=1 -> out_valid falls next cycle, in_ready=1.
4. Bubbles: in_valid toggles 1,0,0,1,0,1,1 carrying the case-1 beats -> dot_out=1920, chunk_idx advances only on accepted beats.
5. Flush after 2 beats, then a full case-2 vector -> dot_out=-1920 (no leftover from the flushed partial).
6. rst_n pulsed low mid-cycle after 3 beats -> out_valid=0, chunk_idx=0 immediately. A following case-1 vector gives dot_out=1920.

Source files
------------

// File: rtl/dot_product_accum_if.sv
// Beat/result handshake bundle for dot_product_accum.
// slave is the accumulator side; master is the J-column feeder plus the
// result consumer.
interface dot_product_accum_if #(
  parameter int LANES           = 64,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int RESULT_WIDTH    = 13,
  parameter int IDX_WIDTH       = 2
);

  logic                              in_valid;
  logic                              in_ready;
  logic [LANES-1:0]                  sigma;
  logic [J_ELEMENT_WIDTH-1:0]        J_chunk [0:LANES-1];
  logic [IDX_WIDTH-1:0]              chunk_idx;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [RESULT_WIDTH-1:0]    dot_out;

  modport master (
    output in_valid, sigma, J_chunk, out_ready,
    input  in_ready, chunk_idx, out_valid, dot_out
  );

  modport slave (
    input  in_valid, sigma, J_chunk, out_ready,
    output in_ready, chunk_idx, out_valid, dot_out
  );

endinterface

// File: rtl/dot_product_accum.sv
// Chunked sigma-weighted dot product.
// Each accepted beat carries LANES J elements and their sigma bits. An adder
// tree reduces the beat, and the tree output is accumulated over CHUNKS beats
// into one signed result. The result is then held until the consumer takes it.
// Optional feature: define DOTACC_PIPE_EN to register the tree output. This
// adds one cycle of result latency and keeps full beat throughput.
module dot_product_accum #(
  parameter int VECTOR_SIZE     = 256,
  parameter int LANES           = 64,
  parameter int J_ELEMENT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  dot_product_accum_if.slave     bus
);

  localparam int RESULT_WIDTH = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE) + 1;
  localparam int CHUNKS       = VECTOR_SIZE / LANES;
  localparam int IDX_WIDTH    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHUNKS - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                          r_state;
  state_t                          w_stateNext;
  logic [IDX_WIDTH-1:0]            r_chunkIdx;
  logic signed [RESULT_WIDTH-1:0]  r_acc;
  logic signed [RESULT_WIDTH-1:0]  r_dotOut;
  logic                            r_outValid;

  logic                            w_inReady;
  logic                            w_accept;
  logic                            w_first;
  logic                            w_last;
  logic signed [RESULT_WIDTH-1:0]  w_tree [0:2*LANES-2];
  logic signed [RESULT_WIDTH-1:0]  w_partial;

  logic                            w_addValid;
  logic                            w_addFirst;
  logic                            w_addLast;
  logic signed [RESULT_WIDTH-1:0]  w_addPartial;
  logic signed [RESULT_WIDTH-1:0]  w_sum;

  assign w_inReady = (r_state == ACCUM);
  assign w_accept  = bus.in_valid && w_inReady && !flush;
  assign w_first   = (r_chunkIdx == '0);
  assign w_last    = (r_chunkIdx == LAST_IDX);

  // Heap-ordered adder tree: leaves hold signed element terms, node n sums 2n+1 and 2n+2
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (bus.sigma[i])
        w_tree[LANES-1+i] = RESULT_WIDTH'(bus.J_chunk[i]);
      else
        w_tree[LANES-1+i] = -RESULT_WIDTH'(bus.J_chunk[i]);
    end
    for (int n = LANES - 2; n >= 0; n--) begin
      w_tree[n] = w_tree[2*n+1] + w_tree[2*n+2];
    end
  end

  assign w_partial = w_tree[0];

`ifdef DOTACC_PIPE_EN
  logic                            r_pValid;
  logic                            r_pFirst;
  logic                            r_pLast;
  logic signed [RESULT_WIDTH-1:0]  r_pPartial;

  // Register the tree output and its position flags so accumulation runs a cycle behind acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pValid   <= 1'b0;
      r_pFirst   <= 1'b0;
      r_pLast    <= 1'b0;
      r_pPartial <= '0;
    end else if (flush) begin
      r_pValid   <= 1'b0;
    end else begin
      r_pValid <= w_accept;
      if (w_accept) begin
        r_pFirst   <= w_first;
        r_pLast    <= w_last;
        r_pPartial <= w_partial;
      end
    end
  end

  assign w_addValid   = r_pValid;
  assign w_addFirst   = r_pFirst;
  assign w_addLast    = r_pLast;
  assign w_addPartial = r_pPartial;
`else
  assign w_addValid   = w_accept;
  assign w_addFirst   = w_first;
  assign w_addLast    = w_last;
  assign w_addPartial = w_partial;
`endif

  // The first beat of a vector overwrites the accumulator, so no clearing cycle is needed
  assign w_sum = w_addFirst ? w_addPartial : (r_acc + w_addPartial);

  // Beat position counter: advances only on accepted beats and wraps after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunkIdx <= '0;
    end else if (flush) begin
      r_chunkIdx <= '0;
    end else if (w_accept) begin
      r_chunkIdx <= w_last ? '0 : (r_chunkIdx + IDX_WIDTH'(1));
    end
  end

  // Accumulate, publish the finished dot product, and drop valid once it is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_dotOut   <= '0;
      r_outValid <= 1'b0;
    end else if (flush) begin
      r_outValid <= 1'b0;
    end else begin
      if (w_addValid) begin
        r_acc <= w_sum;
      end
      if (w_addValid && w_addLast) begin
        r_dotOut   <= w_sum;
        r_outValid <= 1'b1;
      end else if (r_outValid && bus.out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: leave ACCUM on the last accepted beat, leave HOLD on the result handshake
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ACCUM: if (w_accept && w_last) w_stateNext = HOLD;
      HOLD:  if (r_outValid && bus.out_ready) w_stateNext = ACCUM;
      default: w_stateNext = ACCUM;
    endcase
    if (flush) begin
      w_stateNext = ACCUM;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.chunk_idx = r_chunkIdx;
  assign bus.out_valid = r_outValid;
  assign bus.dot_out   = r_dotOut;

endmodule
